// File: rtl/game_pkg.sv
// Shared game constants, player FSM state type and the speed ladder helper.
package game_pkg;

    localparam logic [9:0] MONITOR_WIDTH = 10'd640;
    localparam logic [9:0] PLAYER_WIDTH  = 10'd24;
    localparam logic [9:0] PLAYER_MAX_X  = MONITOR_WIDTH - PLAYER_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_L = 2'd1,
        MOVE_R = 2'd2
    } move_state_t;

    // Step size for a given hold count: 1 below one hold period, 2 below two, else 4.
    function automatic logic [2:0] speed_of(input logic [7:0] cnt, input logic [7:0] ticks);
        if ({1'b0, cnt} < {1'b0, ticks})
            return 3'd1;
        else if ({1'b0, cnt} < {ticks, 1'b0})
            return 3'd2;
        else
            return 3'd4;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one asynchronous button line.
module btn_sync (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Btn,
    output logic o_Btn_Sync
);

    logic meta;

    // Shift the raw level through two flops; both clear on reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            meta       <= 1'b0;
            o_Btn_Sync <= 1'b0;
        end else begin
            meta       <= i_Btn;
            o_Btn_Sync <= meta;
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Player horizontal movement controller: synchronized buttons drive an
// IDLE/MOVE_L/MOVE_R FSM that steps the player X position once per frame tick,
// clamped to [0, MONITOR_WIDTH-PLAYER_WIDTH].
// Optional macro PLAYER_ACCEL_EN: hold-time acceleration (speed 1 -> 2 -> 4).
// Without it the speed is fixed at 1 and no hold counter exists.
module player_move_ctrl #(
    parameter logic [9:0] MONITOR_WIDTH = game_pkg::MONITOR_WIDTH,
    parameter logic [9:0] PLAYER_WIDTH  = game_pkg::PLAYER_WIDTH,
    parameter logic [9:0] START_POS     = 10'd308,
    parameter logic [7:0] HOLD_TICKS    = 8'd16
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Btn_Left,
    input  logic       i_Btn_Right,
    input  logic       i_fTick,
    input  logic       i_Game_En,
    output logic [9:0] o_Player_Position,
    output logic       o_Moving,
    output logic [2:0] o_Speed,
    output logic       o_Edge_Hit
);

    localparam logic [10:0] MAX_X = {1'b0, MONITOR_WIDTH} - {1'b0, PLAYER_WIDTH};

    // A zero hold period makes the speed ladder meaningless.
    if (HOLD_TICKS == 8'd0) begin : g_hold_chk
        $error("HOLD_TICKS must be nonzero");
    end

    game_pkg::move_state_t state, state_nx;
    logic [1:0]  btn_raw, btn_s;   // [0] = left, [1] = right
    logic [9:0]  pos, pos_nx;
    logic        edge_q, edge_nx;
    logic [2:0]  step;
    logic [10:0] sum;

    assign btn_raw = {i_Btn_Right, i_Btn_Left};

    for (genvar g = 0; g < 2; g++) begin : g_sync
        btn_sync u_sync (
            .i_Clk      (i_Clk),
            .i_Rst_n    (i_Rst_n),
            .i_Btn      (btn_raw[g]),
            .o_Btn_Sync (btn_s[g])
        );
    end

`ifdef PLAYER_ACCEL_EN
    logic [7:0] hold_cnt, hold_nx;

    // Hold counter register; saturation is handled in the next-state logic.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) hold_cnt <= '0;
        else          hold_cnt <= hold_nx;
    end

    assign o_Speed = game_pkg::speed_of(hold_cnt, HOLD_TICKS);
`else
    assign o_Speed = 3'd1;
`endif

    // Next state, position and clamp flag; only ticks with the game enabled move.
    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        edge_nx  = 1'b0;
        step     = 3'd1;
        sum      = {1'b0, pos};
`ifdef PLAYER_ACCEL_EN
        hold_nx  = hold_cnt;
`endif
        if (!i_Game_En) begin
            state_nx = game_pkg::IDLE;
`ifdef PLAYER_ACCEL_EN
            hold_nx  = '0;
`endif
        end else if (i_fTick) begin
            unique case (btn_s)
                2'b01:   state_nx = game_pkg::MOVE_L;
                2'b10:   state_nx = game_pkg::MOVE_R;
                default: state_nx = game_pkg::IDLE;
            endcase
`ifdef PLAYER_ACCEL_EN
            // The step used on this tick already reflects the updated hold count.
            if (state_nx == game_pkg::IDLE || state_nx != state)
                hold_nx = '0;
            else if (hold_cnt != 8'hFF)
                hold_nx = hold_cnt + 8'd1;
            step = game_pkg::speed_of(hold_nx, HOLD_TICKS);
`endif
            if (state_nx == game_pkg::MOVE_L) begin
                // Underflow wraps the 11-bit result, so bit 10 flags a negative position.
                sum = {1'b0, pos} - {8'd0, step};
                if (sum[10]) begin
                    pos_nx  = '0;
                    edge_nx = 1'b1;
                end else begin
                    pos_nx  = sum[9:0];
                end
            end else if (state_nx == game_pkg::MOVE_R) begin
                sum = {1'b0, pos} + {8'd0, step};
                if (sum > MAX_X) begin
                    pos_nx  = MAX_X[9:0];
                    edge_nx = 1'b1;
                end else begin
                    pos_nx  = sum[9:0];
                end
            end
        end
    end

    // State, position and edge-hit pulse registers.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state  <= game_pkg::IDLE;
            pos    <= START_POS;
            edge_q <= 1'b0;
        end else begin
            state  <= state_nx;
            pos    <= pos_nx;
            edge_q <= edge_nx;
        end
    end

    assign o_Player_Position = pos;
    assign o_Moving          = (state != game_pkg::IDLE);
    assign o_Edge_Hit        = edge_q;

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 SHALL have parameter MONITOR_WIDTH, default 10'd640, horizontal screen width in pixels.
REQ-002 SHALL have parameter PLAYER_WIDTH, default 10'd24, sprite width in pixels.
REQ-003 SHALL have parameter START_POS, default 10'd308, reset/centre X position.
REQ-004 SHALL have parameter HOLD_TICKS, default 8'd16, frame ticks of continuous hold per speed step.
REQ-005 SHALL have port i_Clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port i_Rst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port i_Btn_Left, input, 1, asynchronous left button, high = pressed.
REQ-008 SHALL have port i_Btn_Right, input, 1, asynchronous right button, high = pressed.
REQ-009 SHALL have port i_fTick, input, 1, one-cycle frame-tick pulse; only moment position may change.
REQ-010 SHALL have port i_Game_En, input, 1, high = movement allowed; low = freeze.
REQ-011 SHALL have port o_Player_Position, output, 10, registered left-edge X of player.
REQ-012 SHALL have port o_Moving, output, 1, high while FSM is in MOVE_L or MOVE_R.
REQ-013 SHALL have port o_Speed, output, 3, current step size in pixels per tick (1, 2 or 4).
REQ-014 SHALL have port o_Edge_Hit, output, 1, one-cycle pulse when a requested move is clamped.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer; the FSM SHALL use only synchronized values (2-cycle input latency).
REQ-016 SHALL implement FSM states IDLE, MOVE_L, MOVE_R, evaluated only on cycles with i_fTick=1 and i_Game_En=1.
REQ-017 SHALL decode on a tick: left only -> MOVE_L; right only -> MOVE_R; none or both -> IDLE (simultaneous press = no move).
REQ-018 SHALL, on a tick in MOVE_L/MOVE_R, update o_Player_Position at that clock edge (visible the next cycle) by -o_Speed/+o_Speed.
REQ-019 SHALL keep an 8-bit saturating hold counter: increments each tick the direction is unchanged; cleared on entry to IDLE or any direction change.
REQ-020 SHALL compute intermediate position in 11 bits; a left result below 0 SHALL clamp to 0; a right result above MONITOR_WIDTH-PLAYER_WIDTH (616) SHALL clamp to 616.
REQ-021 SHALL pulse o_Edge_Hit for the cycle after any tick whose move was clamped, including a request while already at 0 or 616.
REQ-022 SHALL hold position, state, counter and o_Speed constant on cycles without i_fTick.
REQ-023 SHALL, when i_Game_En=0, force state IDLE, clear hold counter, o_Speed=1, o_Edge_Hit=0, and freeze position.
REQ-024 SHALL never change position by more than o_Speed pixels per tick and never exceed [0, 616].

Reset
REQ-025 SHALL, while i_Rst_n=0 at a clock edge, set o_Player_Position=START_POS, state IDLE, hold counter 0, o_Speed=1, o_Moving=0, o_Edge_Hit=0, synchronizer flops 0.
REQ-026 SHALL let reset override an in-progress move; the first tick after release SHALL start from START_POS with speed 1.

Configuration
REQ-027 SHALL honour macro PLAYER_ACCEL_EN: defined -> o_Speed=1 while counter<HOLD_TICKS, 2 while <2*HOLD_TICKS, else 4; undefined -> o_Speed fixed at 1 and the hold counter is removed.

Structure
REQ-028 SHALL take MONITOR_WIDTH, PLAYER_WIDTH, PLAYER_MAX_X (616) and the FSM state enum typedef from shared package game_pkg.
REQ-029 SHALL instantiate sub-module btn_sync (2-flop synchronizer, i_Clk, i_Rst_n, 1-bit in/out) once per button.

Verification
REQ-030 SHALL cover: reset, then right held 10 ticks -> position 308 to 318, o_Speed=1, o_Moving=1.
REQ-031 SHALL cover: both buttons held 5 ticks from 308 -> position stays 308, state IDLE, o_Moving=0.
REQ-032 SHALL cover: position 2, left held 3 ticks -> 1, 0, 0; o_Edge_Hit pulses on the third tick only.
REQ-033 SHALL cover (PLAYER_ACCEL_EN): right held 40 ticks from 308 -> 16 ticks at 1, 16 at 2, 8 at 4; final 388; release then press -> speed 1.
REQ-034 SHALL cover: i_Game_En=0 with left held for 5 ticks -> position frozen; i_Rst_n=0 mid-move at 400 -> next cycle 308, IDLE.
